// File: rtl/cordic_chan_sched_if.sv
// cordic_chan_sched_if: channel requests, rotator link and tagged results of the CORDIC channel scheduler
interface cordic_chan_sched_if #(
   parameter int NCH = 4,
   parameter int CW  = 2,
   parameter int PW  = 32
);
   logic [NCH-1:0]    in_valid;
   logic [NCH-1:0]    in_ready;
   logic [NCH*16-1:0] in_i;
   logic [NCH*16-1:0] in_q;
   logic [NCH*PW-1:0] freq;
   logic              phase_clr;
   logic [15:0]       c_i;
   logic [15:0]       c_q;
   logic [19:0]       c_ain;
   logic [17:0]       c_iout;
   logic [17:0]       c_qout;
   logic              out_valid;
   logic [CW-1:0]     out_ch;
   logic [17:0]       out_i;
   logic [17:0]       out_q;

   modport master (
      output in_valid, in_i, in_q, freq, phase_clr, c_iout, c_qout,
      input  in_ready, c_i, c_q, c_ain, out_valid, out_ch, out_i, out_q
   );

   modport slave (
      input  in_valid, in_i, in_q, freq, phase_clr, c_iout, c_qout,
      output in_ready, c_i, c_q, c_ain, out_valid, out_ch, out_i, out_q
   );
endinterface

// File: rtl/cordic_chan_sched.sv
// cordic_chan_sched: round-robin sharing of one CORDIC rotator between NCH NCO channels with a channel-tag pipeline
module cordic_chan_sched #(
   parameter int NCH = 4,
   parameter int CW  = 2,
   parameter int PW  = 32,
   parameter int LAT = 19
) (
   input logic                clk,
   input logic                rst_n,
   cordic_chan_sched_if.slave bus
);
   logic [CW-1:0]  ptr_q, ptr_d, gnt;
   logic           xfer;
   logic [NCH-1:0] rdy;
   logic [PW-1:0]  acc_q [NCH];
   logic [PW-1:0]  acc_d [NCH];
   logic [15:0]    c_i_q, c_i_d, c_q_q, c_q_d;
   logic [19:0]    c_ain_q, c_ain_d;
   logic           tag_v_q [LAT+1];
   logic           tag_v_d [LAT+1];
   logic [CW-1:0]  tag_ch_q [LAT+1];
   logic [CW-1:0]  tag_ch_d [LAT+1];
   logic           out_valid_q, out_valid_d;
   logic [CW-1:0]  out_ch_q, out_ch_d;
   logic [17:0]    out_i_q, out_i_d, out_q_q, out_q_d;

   // Round-robin grant: first requesting channel at or above the pointer, wrapping
   always_comb begin
      logic [CW:0] idx;
      idx  = '0;
      xfer = 1'b0;
      gnt  = '0;
      for (int j = 0; j < NCH; j++) begin
         idx = {1'b0, ptr_q} + (CW+1)'(j);
         if (idx >= (CW+1)'(NCH))
            idx = idx - (CW+1)'(NCH);
         if (!xfer && bus.in_valid[idx[CW-1:0]]) begin
            xfer = 1'b1;
            gnt  = idx[CW-1:0];
         end
      end
      rdy   = xfer ? (NCH'(1) << gnt) : '0;
      ptr_d = !xfer ? ptr_q : (gnt == CW'(NCH-1)) ? '0 : gnt + 1'b1;
   end

   assign bus.in_ready = rdy;

   // Issue the granted sample with its pre-update phase and advance that channel's NCO
   always_comb begin
      logic          hit;
      logic [PW-1:0] fk;
      hit     = 1'b0;
      fk      = '0;
      c_i_d   = xfer ? bus.in_i[16*gnt +: 16] : c_i_q;
      c_q_d   = xfer ? bus.in_q[16*gnt +: 16] : c_q_q;
      c_ain_d = !xfer ? c_ain_q : bus.phase_clr ? 20'h0 : acc_q[gnt][PW-1 -: 20];
      for (int k = 0; k < NCH; k++) begin
         hit      = xfer && (gnt == CW'(k));
         fk       = bus.freq[PW*k +: PW];
         acc_d[k] = bus.phase_clr ? (hit ? fk : '0) : (hit ? acc_q[k] + fk : acc_q[k]);
      end
   end

   // Channel tags ride alongside the rotator latency; results are captured when a valid tag emerges
   always_comb begin
      tag_v_d[0]  = xfer;
      tag_ch_d[0] = gnt;
      for (int j = 1; j <= LAT; j++) begin
         tag_v_d[j]  = tag_v_q[j-1];
         tag_ch_d[j] = tag_ch_q[j-1];
      end
      out_valid_d = tag_v_q[LAT];
      out_ch_d    = tag_v_q[LAT] ? tag_ch_q[LAT] : out_ch_q;
      out_i_d     = tag_v_q[LAT] ? bus.c_iout : out_i_q;
      out_q_d     = tag_v_q[LAT] ? bus.c_qout : out_q_q;
   end

   // State registers; reset drops every in-flight tag so the unreset rotator cannot emit stale results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         c_i_q       <= '0;
         c_q_q       <= '0;
         c_ain_q     <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_i_q     <= '0;
         out_q_q     <= '0;
         for (int k = 0; k < NCH; k++)
            acc_q[k] <= '0;
         for (int j = 0; j <= LAT; j++) begin
            tag_v_q[j]  <= 1'b0;
            tag_ch_q[j] <= '0;
         end
      end else begin
         ptr_q       <= ptr_d;
         c_i_q       <= c_i_d;
         c_q_q       <= c_q_d;
         c_ain_q     <= c_ain_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         out_i_q     <= out_i_d;
         out_q_q     <= out_q_d;
         for (int k = 0; k < NCH; k++)
            acc_q[k] <= acc_d[k];
         for (int j = 0; j <= LAT; j++) begin
            tag_v_q[j]  <= tag_v_d[j];
            tag_ch_q[j] <= tag_ch_d[j];
         end
      end
   end

   assign bus.c_i       = c_i_q;
   assign bus.c_q       = c_q_q;
   assign bus.c_ain     = c_ain_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_i     = out_i_q;
   assign bus.out_q     = out_q_q;
endmodule

// File: tb/tb_cordic_chan_sched.sv
// tb_cordic_chan_sched: scoreboard bench with a behavioural rotator for the CORDIC channel scheduler
module tb_cordic_chan_sched;
   localparam int  NCH = 4;
   localparam int  CW  = 2;
   localparam int  PW  = 32;
   localparam int  LAT = 19;
   localparam real G   = 53955.0 / 16384.0;
   localparam real TWO_PI = 6.283185307179586;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cordic_chan_sched_if #(.NCH(NCH), .CW(CW), .PW(PW)) bus ();
   cordic_chan_sched #(.NCH(NCH), .CW(CW), .PW(PW), .LAT(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic [CW-1:0] ch;
      logic [17:0]   i;
      logic [17:0]   q;
      int            issue;
   } exp_t;

   exp_t          sb[$];
   int            n_cmp = 0;
   int            n_err = 0;
   int            cyc = 0;
   logic [PW-1:0] acc_m [NCH];
   int            ptr_m = 0;

   function automatic logic [35:0] rot(input logic [15:0] i, input logic [15:0] q, input logic [19:0] a);
      real th, fi, fq, ri, rq;
      th = real'(a) * TWO_PI / 1048576.0;
      fi = real'($signed(i));
      fq = real'($signed(q));
      ri = G * (fi * $cos(th) - fq * $sin(th));
      rq = G * (fi * $sin(th) + fq * $cos(th));
      return {18'(int'(ri)), 18'(int'(rq))};
   endfunction

   // Behavioural rotator: not reset, output reflects the sample issued LAT edges earlier
   logic [15:0] r_i [LAT];
   logic [15:0] r_q [LAT];
   logic [19:0] r_a [LAT];
   logic [35:0] r_out;
   always @(posedge clk) begin
      r_i[0] <= bus.c_i;
      r_q[0] <= bus.c_q;
      r_a[0] <= bus.c_ain;
      for (int j = 1; j < LAT; j++) begin
         r_i[j] <= r_i[j-1];
         r_q[j] <= r_q[j-1];
         r_a[j] <= r_a[j-1];
      end
   end
   always_comb r_out = rot(r_i[LAT-1], r_q[LAT-1], r_a[LAT-1]);
   assign bus.c_iout = r_out[35:18];
   assign bus.c_qout = r_out[17:0];

   // One clock: predict the transfer from the inputs, advance the model, then check any result
   task automatic tick();
      logic          hit;
      logic [CW-1:0] g;
      logic [19:0]   a;
      logic          clr;
      logic [PW-1:0] f;
      logic [35:0]   r;
      exp_t          e;
      hit = 1'b0;
      g = '0;
      for (int j = 0; j < NCH; j++) begin
         int c;
         c = (ptr_m + j) % NCH;
         if (!hit && bus.in_valid[c]) begin
            hit = 1'b1;
            g = CW'(c);
         end
      end
      clr = bus.phase_clr;
      f = bus.freq[PW*g +: PW];
      a = clr ? 20'h0 : acc_m[g][PW-1 -: 20];
      r = rot(bus.in_i[16*g +: 16], bus.in_q[16*g +: 16], a);
      @(posedge clk);
      cyc++;
      if (rst_n) begin
         if (clr)
            for (int k = 0; k < NCH; k++) acc_m[k] = '0;
         if (hit) begin
            acc_m[g] = acc_m[g] + f;
            ptr_m = (int'(g) + 1) % NCH;
            e.ch = g;
            e.i = r[35:18];
            e.q = r[17:0];
            e.issue = cyc;
            sb.push_back(e);
         end
      end
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_result: out_valid=1 out_ch=%0d, required no result pending", bus.out_ch);
         end else begin
            e = sb.pop_front();
            if (bus.out_ch !== e.ch) begin
               n_err++;
               $display("FAIL result_ch: got %0d, required %0d", bus.out_ch, e.ch);
            end
            n_cmp++;
            if (bus.out_i !== e.i || bus.out_q !== e.q) begin
               n_err++;
               $display("FAIL result_iq: got %h/%h, required %h/%h", bus.out_i, bus.out_q, e.i, e.q);
            end
            n_cmp++;
            if (cyc - e.issue != LAT + 1) begin
               n_err++;
               $display("FAIL result_latency: got %0d edges, required %0d", cyc - e.issue, LAT + 1);
            end
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sb.delete();
      ptr_m = 0;
      for (int k = 0; k < NCH; k++) acc_m[k] = '0;
      bus.in_valid = '0;
      bus.phase_clr = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.in_valid = '0;
      while (sb.size() > 0 && n < 40) begin
         tick();
         n++;
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_cmp++;
      if (bus.c_i !== 16'h0 || bus.c_q !== 16'h0 || bus.c_ain !== 20'h0) begin
         n_err++;
         $display("FAIL reset_c: got %h/%h/%h, required 0/0/0", bus.c_i, bus.c_q, bus.c_ain);
      end
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_ch !== '0 || bus.out_i !== 18'h0 || bus.out_q !== 18'h0) begin
         n_err++;
         $display("FAIL reset_out: got v=%b ch=%0d %h/%h, required all 0", bus.out_valid, bus.out_ch, bus.out_i, bus.out_q);
      end
      n_cmp++;
      if (bus.in_ready !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_ready: got %b, required 0000", bus.in_ready);
      end
      tick();
   endtask

   task automatic test_round_robin();
      logic [NCH-1:0] exp_r [5];
      exp_r = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      for (int k = 0; k < NCH; k++) bus.freq[PW*k +: PW] = $urandom;
      bus.in_valid = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         for (int k = 0; k < NCH; k++) begin
            bus.in_i[16*k +: 16] = 16'($urandom_range(0, 65535));
            bus.in_q[16*k +: 16] = 16'($urandom_range(0, 65535));
         end
         #1;
         n_cmp++;
         if (bus.in_ready !== exp_r[n]) begin
            n_err++;
            $display("FAIL rr_ready[%0d]: got %b, required %b", n, bus.in_ready, exp_r[n]);
         end
         tick();
      end
      drain();
   endtask

   task automatic test_alternate();
      logic [NCH-1:0] exp_r [4];
      exp_r = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
      do_reset();
      bus.in_valid = 4'b1001;
      for (int n = 0; n < 4; n++) begin
         bus.in_i[0 +: 16] = 16'(1000 * (n + 1));
         bus.in_i[48 +: 16] = 16'(-2000 * (n + 1));
         #1;
         n_cmp++;
         if (bus.in_ready !== exp_r[n]) begin
            n_err++;
            $display("FAIL alt_ready[%0d]: got %b, required %b", n, bus.in_ready, exp_r[n]);
         end
         tick();
      end
      drain();
   endtask

   task automatic test_phase_wrap();
      logic [19:0] exp_a [5];
      exp_a = '{20'h00000, 20'h40000, 20'h80000, 20'hC0000, 20'h00000};
      do_reset();
      bus.freq[0 +: PW] = 32'h4000_0000;
      bus.in_i[0 +: 16] = 16'd12000;
      bus.in_q[0 +: 16] = 16'd5000;
      bus.in_valid = 4'b0001;
      for (int n = 0; n < 5; n++) begin
         tick();
         n_cmp++;
         if (bus.c_ain !== exp_a[n]) begin
            n_err++;
            $display("FAIL wrap_ain[%0d]: got %h, required %h", n, bus.c_ain, exp_a[n]);
         end
      end
      drain();
   endtask

   task automatic test_latency_gain();
      int  k;
      real m;
      do_reset();
      bus.freq[2*PW +: PW] = '0;
      bus.in_i[32 +: 16] = 16'd16384;
      bus.in_q[32 +: 16] = 16'd0;
      bus.in_valid = 4'b0100;
      tick();
      bus.in_valid = '0;
      k = 0;
      while (k < 30) begin
         tick();
         k++;
         if (bus.out_valid) break;
      end
      n_cmp++;
      if (k != LAT + 1 || !bus.out_valid) begin
         n_err++;
         $display("FAIL gain_latency: got out_valid=%b after %0d edges, required 1 after %0d", bus.out_valid, k, LAT + 1);
      end
      n_cmp++;
      if (bus.out_ch !== 2'd2) begin
         n_err++;
         $display("FAIL gain_ch: got %0d, required 2", bus.out_ch);
      end
      m = $sqrt(real'($signed(bus.out_i)) ** 2 + real'($signed(bus.out_q)) ** 2);
      n_cmp++;
      if (m < 53951.0 || m > 53959.0) begin
         n_err++;
         $display("FAIL gain_mag: got %0f, required 53955 +/-4", m);
      end
      drain();
   endtask

   task automatic test_phase_clr();
      do_reset();
      bus.freq[PW +: PW] = 32'h1000_0000;
      bus.in_i[16 +: 16] = 16'd7000;
      bus.in_q[16 +: 16] = 16'd3000;
      bus.in_valid = 4'b0010;
      repeat (2) tick();
      bus.phase_clr = 1'b1;
      tick();
      n_cmp++;
      if (bus.c_ain !== 20'h0) begin
         n_err++;
         $display("FAIL clr_ain: got %h, required 00000", bus.c_ain);
      end
      bus.phase_clr = 1'b0;
      tick();
      n_cmp++;
      if (bus.c_ain !== 20'h10000) begin
         n_err++;
         $display("FAIL clr_next_ain: got %h, required 10000", bus.c_ain);
      end
      drain();
   endtask

   task automatic test_reset_flush();
      int seen;
      int k;
      do_reset();
      bus.in_valid = 4'b1111;
      repeat (5) tick();
      bus.in_valid = '0;
      repeat (10) tick();
      do_reset();
      seen = 0;
      for (int n = 0; n < 30; n++) begin
         tick();
         if (bus.out_valid) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_err++;
         $display("FAIL flush_quiet: got %0d out_valid strobes, required 0", seen);
      end
      bus.in_i[16 +: 16] = 16'd9000;
      bus.in_valid = 4'b0010;
      tick();
      bus.in_valid = '0;
      k = 0;
      while (k < 30) begin
         tick();
         k++;
         if (bus.out_valid) break;
      end
      n_cmp++;
      if (k != LAT + 1 || !bus.out_valid) begin
         n_err++;
         $display("FAIL flush_restart: got out_valid=%b after %0d edges, required 1 after %0d", bus.out_valid, k, LAT + 1);
      end
      drain();
   endtask

   initial begin
      bus.in_valid = '0;
      bus.in_i = '0;
      bus.in_q = '0;
      bus.freq = '0;
      bus.phase_clr = 1'b0;
      test_reset();
      test_round_robin();
      test_alternate();
      test_phase_wrap();
      test_latency_gain();
      test_phase_clr();
      test_reset_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
